// File: rtl/alu1_str_pkg.sv
// alu1_str_pkg
//   Shared definitions for the ALU1 string sequencer: FSM state encoding,
//   operand-size encodings, EFLAGS bit positions inside the 6-bit CMPS flag
//   vector, and the per-iteration pointer step helper.
package alu1_str_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHK    = 3'd1,
    ST_RD_SRC = 3'd2,
    ST_RD_DST = 3'd3,
    ST_WR_DST = 3'd4,
    ST_CMP    = 3'd5,
    ST_UPD    = 3'd6,
    ST_DONE   = 3'd7
  } str_state_e;

  localparam logic [1:0] SIZE_BYTE  = 2'b00;
  localparam logic [1:0] SIZE_WORD  = 2'b01;
  localparam logic [1:0] SIZE_DWORD = 2'b10;

  // Bit positions inside cmps_flags_in / flags_out ({OF,SF,ZF,AF,PF,CF}).
  localparam int unsigned FLAG_CF = 32'd0;
  localparam int unsigned FLAG_PF = 32'd1;
  localparam int unsigned FLAG_AF = 32'd2;
  localparam int unsigned FLAG_ZF = 32'd3;
  localparam int unsigned FLAG_SF = 32'd4;
  localparam int unsigned FLAG_OF = 32'd5;

  // Encoding 11 is not a legal size; it behaves as a dword.
  function automatic logic [1:0] str_norm_size(input logic [1:0] size);
    logic [1:0] res;
    case (size)
      SIZE_BYTE: res = SIZE_BYTE;
      SIZE_WORD: res = SIZE_WORD;
      default:   res = SIZE_DWORD;
    endcase
    return res;
  endfunction

  // Signed pointer step: element size in bytes, negated when counting down.
  function automatic logic signed [3:0] str_step(input logic [1:0] size, input logic df);
    logic signed [3:0] mag;
    case (size)
      SIZE_BYTE: mag = 4'sd1;
      SIZE_WORD: mag = 4'sd2;
      default:   mag = 4'sd4;
    endcase
    return df ? -mag : mag;
  endfunction

endpackage

// File: rtl/alu1_str_ptr.sv
// alu1_str_ptr
//   Combinational next-value logic for the string working registers.
//   Ports:
//     esi, edi  in   current source/destination pointers
//     ecx       in   current count
//     size      in   normalised operand size
//     df        in   direction flag (1 = decrement)
//     rep_en    in   count is only consumed under a REP prefix
//     esi_next, edi_next, ecx_next  out  stepped values (modulo wrap)
module alu1_str_ptr
  import alu1_str_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic [ADDR_W-1:0] esi,
  input  logic [ADDR_W-1:0] edi,
  input  logic [CNT_W-1:0]  ecx,
  input  logic [1:0]        size,
  input  logic              df,
  input  logic              rep_en,
  output logic [ADDR_W-1:0] esi_next,
  output logic [ADDR_W-1:0] edi_next,
  output logic [CNT_W-1:0]  ecx_next
);

  logic signed [3:0]  step_s;
  logic [ADDR_W-1:0]  step_ext_s;

  // Sign-extend the small step to pointer width; plain addition then wraps.
  always_comb begin
    step_s     = str_step(size, df);
    step_ext_s = {{(ADDR_W-4){step_s[3]}}, step_s};
    esi_next   = esi + step_ext_s;
    edi_next   = edi + step_ext_s;
    if (rep_en) begin
      ecx_next = ecx - CNT_W'(1);
    end else begin
      ecx_next = ecx;
    end
  end

endmodule

// File: rtl/alu1_str_seq.sv
// alu1_str_seq
//   Execute-stage sequencer for MOVS/CMPS (optionally REP/REPE/REPNE) around
//   ALU1. Owns working ESI/EDI/ECX, runs the memory read/write handshakes,
//   strobes mem_latch_en on source reads, captures CMPS flags and decides
//   REP termination (count exhausted, ZF condition, or pending interrupt).
//   Ports:
//     clk, rst (async active-low), flush
//     start + op controls (op_cmps, rep_en, rep_z, op_size, df, esi_in, edi_in, ecx_in)
//     intr_pend       interrupt pending, looked at between iterations only
//     mem_rd_ack/mem_wr_ack, mem_rd_req/mem_wr_req, mem_addr, mem_size, mem_latch_en
//     cmps_flags_in -> flags_out / flags_ld, alu1_op_size
//     esi_out/edi_out/ecx_out working registers, busy, done, intr_abort
module alu1_str_seq
  import alu1_str_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              start,
  input  logic              op_cmps,
  input  logic              rep_en,
  input  logic              rep_z,
  input  logic [1:0]        op_size,
  input  logic              df,
  input  logic [ADDR_W-1:0] esi_in,
  input  logic [ADDR_W-1:0] edi_in,
  input  logic [CNT_W-1:0]  ecx_in,
  input  logic              intr_pend,
  input  logic              mem_rd_ack,
  input  logic              mem_wr_ack,
  input  logic [5:0]        cmps_flags_in,
  output logic              busy,
  output logic              mem_rd_req,
  output logic              mem_wr_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_size,
  output logic              mem_latch_en,
  output logic [1:0]        alu1_op_size,
  output logic [5:0]        flags_out,
  output logic              flags_ld,
  output logic [ADDR_W-1:0] esi_out,
  output logic [ADDR_W-1:0] edi_out,
  output logic [CNT_W-1:0]  ecx_out,
  output logic              done,
  output logic              intr_abort
);

  str_state_e        state_r;
  logic              op_cmps_r;
  logic              rep_en_r;
  logic              rep_z_r;
  logic [1:0]        size_r;
  logic              df_r;
  logic [ADDR_W-1:0] esi_r;
  logic [ADDR_W-1:0] edi_r;
  logic [CNT_W-1:0]  ecx_r;
  logic [5:0]        flags_r;
  logic              rd_req_r;
  logic              wr_req_r;
  logic              busy_r;
  logic              done_r;
  logic              flags_ld_r;
  logic              intr_abort_r;

  logic [ADDR_W-1:0] esi_next_s;
  logic [ADDR_W-1:0] edi_next_s;
  logic [CNT_W-1:0]  ecx_next_s;
  logic              zf_stop_s;
  logic              term_s;
  logic              abort_s;

  alu1_str_ptr #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_ptr (
    .esi      (esi_r),
    .edi      (edi_r),
    .ecx      (ecx_r),
    .size     (size_r),
    .df       (df_r),
    .rep_en   (rep_en_r),
    .esi_next (esi_next_s),
    .edi_next (edi_next_s),
    .ecx_next (ecx_next_s)
  );

  // Iteration exit decision; uses flags captured in CMP, which are already in flags_r by UPD.
  always_comb begin
    zf_stop_s = 1'b0;
    if (op_cmps_r) begin
      if (rep_z_r) begin
        zf_stop_s = !flags_r[FLAG_ZF];
      end else begin
        zf_stop_s = flags_r[FLAG_ZF];
      end
    end else begin
      zf_stop_s = 1'b0;
    end
    term_s  = !rep_en_r || (ecx_next_s == {CNT_W{1'b0}}) || zf_stop_s;
    // A natural termination in the same step is reported as a normal finish.
    abort_s = intr_pend && !term_s;
  end

  // Sequencer FSM with all working registers and registered strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      op_cmps_r    <= 1'b0;
      rep_en_r     <= 1'b0;
      rep_z_r      <= 1'b0;
      size_r       <= 2'b00;
      df_r         <= 1'b0;
      esi_r        <= {ADDR_W{1'b0}};
      edi_r        <= {ADDR_W{1'b0}};
      ecx_r        <= {CNT_W{1'b0}};
      flags_r      <= 6'b000000;
      rd_req_r     <= 1'b0;
      wr_req_r     <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      flags_ld_r   <= 1'b0;
      intr_abort_r <= 1'b0;
    end else if (flush) begin
      // Abandon the op; any ack arriving now is dropped with it.
      state_r      <= ST_IDLE;
      rd_req_r     <= 1'b0;
      wr_req_r     <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      flags_ld_r   <= 1'b0;
      intr_abort_r <= 1'b0;
    end else begin
      done_r       <= 1'b0;
      flags_ld_r   <= 1'b0;
      intr_abort_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            op_cmps_r <= op_cmps;
            rep_en_r  <= rep_en;
            rep_z_r   <= rep_z;
            size_r    <= str_norm_size(op_size);
            df_r      <= df;
            esi_r     <= esi_in;
            edi_r     <= edi_in;
            ecx_r     <= ecx_in;
            busy_r    <= 1'b1;
            state_r   <= ST_CHK;
          end else begin
            state_r   <= ST_IDLE;
          end
        end
        ST_CHK: begin
          if (rep_en_r && (ecx_r == {CNT_W{1'b0}})) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
          end else begin
            state_r  <= ST_RD_SRC;
            rd_req_r <= 1'b1;
          end
        end
        ST_RD_SRC: begin
          if (mem_rd_ack) begin
            if (op_cmps_r) begin
              state_r  <= ST_RD_DST;
            end else begin
              state_r  <= ST_WR_DST;
              rd_req_r <= 1'b0;
              wr_req_r <= 1'b1;
            end
          end else begin
            state_r <= ST_RD_SRC;
          end
        end
        ST_RD_DST: begin
          if (mem_rd_ack) begin
            state_r  <= ST_CMP;
            rd_req_r <= 1'b0;
          end else begin
            state_r <= ST_RD_DST;
          end
        end
        ST_WR_DST: begin
          if (mem_wr_ack) begin
            state_r  <= ST_UPD;
            wr_req_r <= 1'b0;
          end else begin
            state_r <= ST_WR_DST;
          end
        end
        ST_CMP: begin
          flags_r    <= cmps_flags_in;
          flags_ld_r <= 1'b1;
          state_r    <= ST_UPD;
        end
        ST_UPD: begin
          esi_r <= esi_next_s;
          edi_r <= edi_next_s;
          ecx_r <= ecx_next_s;
          if (term_s || intr_pend) begin
            state_r      <= ST_DONE;
            done_r       <= 1'b1;
            intr_abort_r <= abort_s;
          end else begin
            state_r  <= ST_RD_SRC;
            rd_req_r <= 1'b1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r  <= ST_IDLE;
          rd_req_r <= 1'b0;
          wr_req_r <= 1'b0;
          busy_r   <= 1'b0;
        end
      endcase
    end
  end

  // Requests are masked by flush so they drop in the flush cycle itself.
  assign mem_rd_req   = rd_req_r && !flush;
  assign mem_wr_req   = wr_req_r && !flush;
  // The strobe must coincide with the read ack, when mem_out carries the data.
  assign mem_latch_en = (state_r == ST_RD_SRC) && rd_req_r && mem_rd_ack && !flush;
  assign mem_addr     = (state_r == ST_RD_SRC) ? esi_r : edi_r;
  assign mem_size     = size_r;
  assign alu1_op_size = size_r;
  assign flags_out    = flags_r;
  assign flags_ld     = flags_ld_r;
  assign esi_out      = esi_r;
  assign edi_out      = edi_r;
  assign ecx_out      = ecx_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign intr_abort   = intr_abort_r;

endmodule

// File: tb/tb_alu1_str_seq.sv
// tb_alu1_str_seq
//   Directed bench for alu1_str_seq. A transaction-level model expands each
//   string op into its expected memory accesses, flag loads and final register
//   values; one compare process checks the DUT against it every cycle, and
//   hand-computed literals pin the model results.
module tb_alu1_str_seq;

  logic        clk = 1'b0;
  logic        rst, flush, start, op_cmps, rep_en, rep_z, df, intr_pend;
  logic [1:0]  op_size;
  logic [31:0] esi_in, edi_in, ecx_in;
  logic        mem_rd_ack, mem_wr_ack;
  logic [5:0]  cmps_flags_in;
  logic        busy, mem_rd_req, mem_wr_req, mem_latch_en, flags_ld, done, intr_abort;
  logic [31:0] mem_addr, esi_out, edi_out, ecx_out;
  logic [1:0]  mem_size, alu1_op_size;
  logic [5:0]  flags_out;

  alu1_str_seq #(.ADDR_W(32), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .start(start), .op_cmps(op_cmps),
    .rep_en(rep_en), .rep_z(rep_z), .op_size(op_size), .df(df),
    .esi_in(esi_in), .edi_in(edi_in), .ecx_in(ecx_in), .intr_pend(intr_pend),
    .mem_rd_ack(mem_rd_ack), .mem_wr_ack(mem_wr_ack), .cmps_flags_in(cmps_flags_in),
    .busy(busy), .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
    .mem_size(mem_size), .mem_latch_en(mem_latch_en), .alu1_op_size(alu1_op_size),
    .flags_out(flags_out), .flags_ld(flags_ld), .esi_out(esi_out), .edi_out(edi_out),
    .ecx_out(ecx_out), .done(done), .intr_abort(intr_abort)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  logic [33:0] exp_acc[$];    // {kind,addr}: kind 0=src read, 1=dst read, 2=write
  logic [5:0]  exp_flags[$];
  logic [5:0]  flags_tab[8];
  logic [31:0] e_esi, e_edi, e_ecx;
  logic [1:0]  e_size;
  logic        e_abort;
  logic        model_active = 1'b0;

  task automatic model_build(input logic cmps, input logic rep, input logic rz,
                             input logic [1:0] sz, input logic d,
                             input logic [31:0] si, input logic [31:0] di,
                             input logic [31:0] cx, input int intr_iter);
    int step;
    int it;
    logic zf;
    exp_acc.delete();
    exp_flags.delete();
    step = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    if (d) step = -step;
    e_size  = (sz == 2'b11) ? 2'b10 : sz;
    e_esi   = si;
    e_edi   = di;
    e_ecx   = cx;
    e_abort = 1'b0;
    zf      = 1'b0;
    if (!(rep && cx == 32'd0)) begin
      it = 0;
      while (1) begin
        it++;
        exp_acc.push_back({2'd0, e_esi});
        if (cmps) begin
          exp_acc.push_back({2'd1, e_edi});
          exp_flags.push_back(flags_tab[(it-1) % 8]);
          zf = flags_tab[(it-1) % 8][3];
        end else begin
          exp_acc.push_back({2'd2, e_edi});
        end
        e_esi = e_esi + 32'(step);
        e_edi = e_edi + 32'(step);
        if (rep) e_ecx = e_ecx - 32'd1;
        if (!rep || e_ecx == 32'd0 || (cmps && (rz ? !zf : zf))) break;
        if (it == intr_iter) begin
          e_abort = 1'b1;
          break;
        end
      end
    end
  endtask

  // ---------------- memory responder ----------------
  int ack_lat = 0;
  int wait_cnt = 0;
  // Acks a held request after ack_lat extra cycles of waiting.
  always @(negedge clk) begin
    mem_rd_ack = 1'b0;
    mem_wr_ack = 1'b0;
    if (mem_rd_req || mem_wr_req) begin
      if (wait_cnt >= ack_lat) begin
        mem_rd_ack = mem_rd_req;
        mem_wr_ack = mem_wr_req;
        wait_cnt   = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // ---------------- compare process ----------------
  always begin
    logic [33:0] a;
    @(negedge clk);
    #2;
    if (model_active) begin
      if ((mem_rd_req && mem_rd_ack) || (mem_wr_req && mem_wr_ack)) begin
        if (exp_acc.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL acc_extra actual_addr=%0h expected=none", mem_addr);
        end else begin
          a = exp_acc.pop_front();
          chk("acc_is_write", {63'd0, mem_wr_req}, {63'd0, (a[33:32] == 2'd2)});
          chk("acc_addr", {32'd0, mem_addr}, {32'd0, a[31:0]});
          chk("latch_en", {63'd0, mem_latch_en}, {63'd0, (a[33:32] == 2'd0)});
        end
      end else begin
        chk("latch_idle", {63'd0, mem_latch_en}, 64'd0);
      end
      if (mem_rd_req || mem_wr_req) chk("mem_size", {62'd0, mem_size}, {62'd0, e_size});
      if (flags_ld) begin
        if (exp_flags.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL flags_ld_extra actual=%0h expected=none", flags_out);
        end else begin
          chk("flags_out", {58'd0, flags_out}, {58'd0, exp_flags.pop_front()});
        end
      end
      if (done) begin
        chk("done_esi", {32'd0, esi_out}, {32'd0, e_esi});
        chk("done_edi", {32'd0, edi_out}, {32'd0, e_edi});
        chk("done_ecx", {32'd0, ecx_out}, {32'd0, e_ecx});
        chk("done_abort", {63'd0, intr_abort}, {63'd0, e_abort});
        chk("done_size", {62'd0, alu1_op_size}, {62'd0, e_size});
        chk("acc_left", 64'(exp_acc.size()), 64'd0);
        chk("flags_left", 64'(exp_flags.size()), 64'd0);
      end
    end
  end

  // ---------------- op driver ----------------
  logic [31:0] d_esi, d_edi, d_ecx;
  logic [5:0]  d_flags;
  logic        d_abort;
  int          d_n, n_fld, n_req, n_latch, cmp_idx;

  // Runs one op to completion; exp_n>0 checks cycles from start to done.
  task automatic run_op(input string tag, input logic cmps, input logic rep, input logic rz,
                        input logic [1:0] sz, input logic d, input logic [31:0] si,
                        input logic [31:0] di, input logic [31:0] cx, input int intr_iter,
                        input int lat, input int hold_start, input int exp_n);
    logic got;
    model_build(cmps, rep, rz, sz, d, si, di, cx, intr_iter);
    ack_lat = lat;
    cmp_idx = 0;
    n_fld = 0; n_req = 0; n_latch = 0; d_n = 0;
    got = 1'b0;
    @(negedge clk);
    op_cmps = cmps; rep_en = rep; rep_z = rz; op_size = sz; df = d;
    esi_in = si; edi_in = di; ecx_in = cx; intr_pend = 1'b0;
    cmps_flags_in = flags_tab[0];
    start = 1'b1;
    model_active = 1'b1;
    for (int n = 1; n <= 400 && !got; n++) begin
      @(negedge clk);
      #3;
      if (n >= hold_start) start = 1'b0;
      if (n == 1) chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
      if (mem_rd_req || mem_wr_req) n_req++;
      if (mem_latch_en) begin
        n_latch++;
        if (n_latch == intr_iter) intr_pend = 1'b1;
      end
      if (flags_ld) begin
        n_fld++;
        cmp_idx++;
        cmps_flags_in = flags_tab[cmp_idx % 8];
      end
      if (done) begin
        got = 1'b1;
        d_n = n; d_esi = esi_out; d_edi = edi_out; d_ecx = ecx_out;
        d_abort = intr_abort; d_flags = flags_out;
      end
    end
    model_active = 1'b0;
    start = 1'b0;
    if (!got) begin
      n_chk++;
      n_err++;
      $display("FAIL %s_timeout actual=no_done expected=done", tag);
    end
    if (exp_n > 0) chk({tag, "_latency"}, 64'(d_n), 64'(exp_n));
    @(negedge clk);
    #3;
    intr_pend = 1'b0;
    chk({tag, "_done_once"}, {63'd0, done}, 64'd0);
    chk({tag, "_idle_busy"}, {63'd0, busy}, 64'd0);
  endtask

  task automatic start_pulse(input logic [31:0] si, input logic [31:0] di);
    @(negedge clk);
    op_cmps = 1'b0; rep_en = 1'b0; rep_z = 1'b0; op_size = 2'b01; df = 1'b0;
    esi_in = si; edi_in = di; ecx_in = 32'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic logic outs_any();
    return |{busy, mem_rd_req, mem_wr_req, mem_addr, mem_size, mem_latch_en, alu1_op_size,
             flags_out, flags_ld, esi_out, edi_out, ecx_out, done, intr_abort};
  endfunction

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    logic seen;
    rst = 1'b0; flush = 1'b0; start = 1'b0; op_cmps = 1'b0; rep_en = 1'b0; rep_z = 1'b0;
    op_size = 2'b00; df = 1'b0; esi_in = 32'd0; edi_in = 32'd0; ecx_in = 32'd0;
    intr_pend = 1'b0; cmps_flags_in = 6'd0; mem_rd_ack = 1'b0; mem_wr_ack = 1'b0;
    for (int i = 0; i < 8; i++) flags_tab[i] = 6'd0;
    repeat (3) @(negedge clk);
    #2;
    chk("reset_outputs", {63'd0, outs_any()}, 64'd0);
    rst = 1'b1;

    // 1: MOVS word; done in the 6th cycle counting the start cycle as 1.
    run_op("movs_word", 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 32'h100, 32'h200, 32'd7, 0, 0, 1, 5);
    chk("t1_esi", {32'd0, d_esi}, 64'h102);
    chk("t1_edi", {32'd0, d_edi}, 64'h202);
    chk("t1_ecx", {32'd0, d_ecx}, 64'd7);
    chk("t1_req_cycles", 64'(n_req), 64'd2);

    // 2: REP MOVS byte, counting down; start held while busy must be ignored.
    run_op("rep_movs_dn", 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 32'h10, 32'h1, 32'd3, 0, 0, 3, 0);
    chk("t2_esi", {32'd0, d_esi}, 64'h0D);
    chk("t2_edi", {32'd0, d_edi}, 64'hFFFFFFFE);
    chk("t2_ecx", {32'd0, d_ecx}, 64'd0);
    chk("t2_abort", {63'd0, d_abort}, 64'd0);
    chk("t2_latches", 64'(n_latch), 64'd3);

    // 3: REP with ecx=0: no memory traffic, done two cycles after start.
    run_op("rep_ecx0", 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h80, 32'd0, 0, 0, 1, 2);
    chk("t3_req_cycles", 64'(n_req), 64'd0);
    chk("t3_flags_ld", 64'(n_fld), 64'd0);

    // Non-REP CMPS: one extra cycle versus MOVS.
    flags_tab[0] = 6'b010011;
    run_op("cmps_single", 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h300, 32'h400, 32'd9, 0, 0, 1, 6);
    chk("tc_flags", {58'd0, d_flags}, 64'h13);

    // 4: REPE CMPS dword, ZF drops on the 2nd compare.
    flags_tab[0] = 6'b001000;
    flags_tab[1] = 6'b100101;
    run_op("repe_cmps", 1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 32'h1000, 32'h2000, 32'd5, 0, 1, 1, 0);
    chk("t4_flags_ld", 64'(n_fld), 64'd2);
    chk("t4_ecx", {32'd0, d_ecx}, 64'd3);
    chk("t4_esi", {32'd0, d_esi}, 64'h1008);
    chk("t4_flags", {58'd0, d_flags}, 64'h25);

    // REPNE CMPS with size 11 (dword), counting down, ZF sets on 3rd compare.
    flags_tab[0] = 6'b000100;
    flags_tab[1] = 6'b000000;
    flags_tab[2] = 6'b001001;
    run_op("repne_cmps", 1'b1, 1'b1, 1'b0, 2'b11, 1'b1, 32'h40, 32'h90, 32'd4, 0, 0, 1, 0);
    chk("tn_ecx", {32'd0, d_ecx}, 64'd1);
    chk("tn_esi", {32'd0, d_esi}, 64'h34);

    // 5: interrupt raised during the 4th iteration of a 10-count REP MOVS.
    run_op("rep_intr", 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 32'h800, 32'h900, 32'd10, 4, 1, 1, 0);
    chk("t5_abort", {63'd0, d_abort}, 64'd1);
    chk("t5_ecx", {32'd0, d_ecx}, 64'd6);

    // Interrupt on the last iteration: termination wins, no abort.
    run_op("intr_last", 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h20, 32'h30, 32'd2, 2, 0, 1, 0);
    chk("tl_abort", {63'd0, d_abort}, 64'd0);

    // 6a: async reset while a read is pending with slow acks.
    ack_lat = 3;
    start_pulse(32'h500, 32'h600);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (mem_rd_req) seen = 1'b1;
    end
    chk("t6_rst_req_seen", {63'd0, seen}, 64'd1);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("t6_rst_outputs", {63'd0, outs_any()}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // 6b: flush arriving together with the read ack: ack dropped, no done.
    start_pulse(32'h500, 32'h600);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (mem_rd_ack) seen = 1'b1;
    end
    chk("t6_ack_seen", {63'd0, seen}, 64'd1);
    flush = 1'b1;
    #1;
    chk("t6_flush_rd_req", {63'd0, mem_rd_req}, 64'd0);
    chk("t6_flush_latch", {63'd0, mem_latch_en}, 64'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("t6_flush_busy", {63'd0, busy}, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      if (done || mem_rd_req || mem_wr_req) seen = 1'b1;
    end
    chk("t6_flush_quiet", {63'd0, seen}, 64'd0);
    chk("t6_flush_esi", {32'd0, esi_out}, 64'h500);

    // Clean restart after flush, slow acks, plus pointer wrap.
    run_op("wrap_word", 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd0, 0, 3, 1, 0);
    chk("tw_esi", {32'd0, d_esi}, 64'h1);
    chk("tw_edi", {32'd0, d_edi}, 64'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
